quad_raster_ctrl: RTL

- Sequences the per-pixel texture_mapping datapath for one screen-space quad at a time.
- Accepts a quad (4 vertices with x/y/u/v/z) over a valid/ready handshake and latches it.
- Computes a clamped bounding box, scans it row-major by driving the mapper's query point, and aligns the mapper's 1-cycle-latency result.
- Emits inside pixels (x, y, u, v, z) on a backpressured stream to the depth-test/framebuffer stage.

---
 rtl/quad_raster_ctrl.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/quad_raster_ctrl.sv
// quad_raster_ctrl
// Runs the per-pixel texture-mapping datapath for one screen-space quad at
// a time. A quad is accepted and latched, then its bounding box is computed
// and clamped to the screen. The box is scanned row-major by driving the
// mapper query point. The mapper's 1-cycle-late results are realigned with
// the coordinate that produced them. Inside pixels are streamed out through
// a 2-entry FIFO that honours downstream backpressure.
//
// Ports:
//   CLK, RESET            clock, asynchronous active-high reset
//   in_valid/in_ready     quad descriptor handshake
//   in_x/y/u/v/z[4]       vertex data (x/y/u/v 10-bit signed, z 16-bit signed)
//   m_x/y/u/v/z[4]        latched vertices presented to the mapper
//   m_qx, m_qy            mapper query point
//   m_inside, m_qu/qv/qz  mapper result for the previous cycle's query
//   pix_valid/pix_ready   output pixel stream handshake
//   pix_x/y/u/v/z         output pixel fields (FIFO head)
//   busy, done            activity flag, one-cycle end-of-quad pulse
//   pix_count             pixels emitted for the current or last quad
module quad_raster_ctrl #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [9:0]  in_x [4],
  input  logic signed [9:0]  in_y [4],
  input  logic signed [9:0]  in_u [4],
  input  logic signed [9:0]  in_v [4],
  input  logic signed [15:0] in_z [4],
  output logic signed [9:0]  m_x [4],
  output logic signed [9:0]  m_y [4],
  output logic signed [9:0]  m_u [4],
  output logic signed [9:0]  m_v [4],
  output logic signed [15:0] m_z [4],
  output logic signed [9:0]  m_qx,
  output logic signed [9:0]  m_qy,
  input  logic               m_inside,
  input  logic signed [3:0]  m_qu,
  input  logic signed [3:0]  m_qv,
  input  logic signed [15:0] m_qz,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [9:0]         pix_x,
  output logic [9:0]         pix_y,
  output logic [3:0]         pix_u,
  output logic [3:0]         pix_v,
  output logic [15:0]        pix_z,
  output logic               busy,
  output logic               done,
  output logic [18:0]        pix_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_BBOX  = 3'd1;
  localparam logic [2:0] S_SCAN  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic signed [11:0] X_LAST = 12'(SCREEN_W - 1);
  localparam logic signed [11:0] Y_LAST = 12'(SCREEN_H - 1);

  logic [2:0]         state_q, state_d;
  logic signed [9:0]  vx_q [4];
  logic signed [9:0]  vy_q [4];
  logic signed [9:0]  vu_q [4];
  logic signed [9:0]  vv_q [4];
  logic signed [15:0] vz_q [4];
  logic [9:0]         qx_q, qx_d, qy_q, qy_d;
  logic [9:0]         xmin_q, xmin_d, xmax_q, xmax_d, ymax_q, ymax_d;
  logic [9:0]         dly_x_q, dly_x_d, dly_y_q, dly_y_d;
  logic               inflight_q;
  logic [43:0]        fifo_q [2];
  logic               wr_ptr_q, rd_ptr_q;
  logic [1:0]         cnt_q;
  logic [18:0]        pix_count_q;

  logic accept, push, pop, issue;
  logic [1:0] occ;

  assign accept = (state_q == S_IDLE) && in_valid;

  // Vertex registers: loaded only on acceptance, constant until the next quad.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_vert
      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
          vx_q[gi] <= '0;
          vy_q[gi] <= '0;
          vu_q[gi] <= '0;
          vv_q[gi] <= '0;
          vz_q[gi] <= '0;
        end else if (accept) begin
          vx_q[gi] <= in_x[gi];
          vy_q[gi] <= in_y[gi];
          vu_q[gi] <= in_u[gi];
          vv_q[gi] <= in_v[gi];
          vz_q[gi] <= in_z[gi];
        end
      end
      assign m_x[gi] = vx_q[gi];
      assign m_y[gi] = vy_q[gi];
      assign m_u[gi] = vu_q[gi];
      assign m_v[gi] = vv_q[gi];
      assign m_z[gi] = vz_q[gi];
    end
  endgenerate

  // Bounding box of the latched vertices.
  logic signed [9:0]  x_lo, x_hi, y_lo, y_hi;
  logic signed [11:0] x_lo_w, x_hi_w, y_lo_w, y_hi_w;
  logic [9:0]         cx_lo, cx_hi, cy_lo, cy_hi;
  logic               box_empty;

  always_comb begin
    x_lo = vx_q[0];
    x_hi = vx_q[0];
    y_lo = vy_q[0];
    y_hi = vy_q[0];
    for (int i = 1; i < 4; i++) begin
      if (vx_q[i] < x_lo) x_lo = vx_q[i];
      if (vx_q[i] > x_hi) x_hi = vx_q[i];
      if (vy_q[i] < y_lo) y_lo = vy_q[i];
      if (vy_q[i] > y_hi) y_hi = vy_q[i];
    end
  end

  function automatic logic [9:0] clamp_coord(input logic signed [11:0] v,
                                             input logic signed [11:0] last);
    if (v < 12'sd0)     return 10'd0;
    else if (v > last)  return last[9:0];
    else                return v[9:0];
  endfunction

  assign x_lo_w = {{2{x_lo[9]}}, x_lo};
  assign x_hi_w = {{2{x_hi[9]}}, x_hi};
  assign y_lo_w = {{2{y_lo[9]}}, y_lo};
  assign y_hi_w = {{2{y_hi[9]}}, y_hi};
  assign cx_lo  = clamp_coord(x_lo_w, X_LAST);
  assign cx_hi  = clamp_coord(x_hi_w, X_LAST);
  assign cy_lo  = clamp_coord(y_lo_w, Y_LAST);
  assign cy_hi  = clamp_coord(y_hi_w, Y_LAST);
  assign box_empty = (x_hi_w < 12'sd0) || (x_lo_w > X_LAST) ||
                     (y_hi_w < 12'sd0) || (y_lo_w > Y_LAST) ||
                     (cx_lo > cx_hi) || (cy_lo > cy_hi);

  // Credit check: FIFO entries plus the result still in the mapper must
  // leave room for the query issued now. A pop this cycle frees its slot
  // immediately, which keeps the scan at one query per cycle when the sink
  // is always ready.
  assign pop  = (cnt_q != 2'd0) && pix_ready;
  assign push = inflight_q && m_inside;
  assign occ  = cnt_q - {1'b0, pop} + {1'b0, inflight_q};

  always_comb begin
    state_d = state_q;
    qx_d    = qx_q;
    qy_d    = qy_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymax_d  = ymax_q;
    dly_x_d = dly_x_q;
    dly_y_d = dly_y_q;
    issue   = 1'b0;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_BBOX;
      S_BBOX: begin
        if (box_empty) begin
          state_d = S_DONE;
        end else begin
          xmin_d  = cx_lo;
          xmax_d  = cx_hi;
          ymax_d  = cy_hi;
          qx_d    = cx_lo;
          qy_d    = cy_lo;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (occ < 2'd2) begin
          issue   = 1'b1;
          dly_x_d = qx_q;
          dly_y_d = qy_q;
          if (qx_q == xmax_q) begin
            if (qy_q == ymax_q) begin
              state_d = S_DRAIN;
            end else begin
              qx_d = xmin_q;
              qy_d = qy_q + 10'd1;
            end
          end else begin
            qx_d = qx_q + 10'd1;
          end
        end
      end
      S_DRAIN: if (!inflight_q && cnt_q == 2'd0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      qx_q        <= '0;
      qy_q        <= '0;
      xmin_q      <= '0;
      xmax_q      <= '0;
      ymax_q      <= '0;
      dly_x_q     <= '0;
      dly_y_q     <= '0;
      inflight_q  <= 1'b0;
      pix_count_q <= '0;
    end else begin
      state_q    <= state_d;
      qx_q       <= qx_d;
      qy_q       <= qy_d;
      xmin_q     <= xmin_d;
      xmax_q     <= xmax_d;
      ymax_q     <= ymax_d;
      dly_x_q    <= dly_x_d;
      dly_y_q    <= dly_y_d;
      inflight_q <= issue;
      if (accept)   pix_count_q <= '0;
      else if (pop) pix_count_q <= pix_count_q + 19'd1;
    end
  end

  // Two-entry result FIFO; results with m_inside=0 are never written.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= {dly_x_q, dly_y_q, m_qu, m_qv, m_qz};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  no_fifo_overflow: assert property (@(posedge CLK) disable iff (RESET)
    !(push && !pop && cnt_q == 2'd2));

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign pix_valid = (cnt_q != 2'd0);
  assign {pix_x, pix_y, pix_u, pix_v, pix_z} = fifo_q[rd_ptr_q];
  assign pix_count = pix_count_q;
  assign m_qx      = $signed(qx_q);
  assign m_qy      = $signed(qy_q);

endmodule
